// File: rtl/core_logic_prog.sv
// Programmable table-driven state machine: a {state, X}-indexed transition table
// with a valid bit per entry, forced-state load, registered table readback and a step counter.
module core_logic_prog #(
    parameter int             SW          = 4,
    parameter int             XW          = 4,
    parameter int             CW          = 16,
    parameter logic [SW-1:0]  RESET_STATE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XW-1:0]     X,
    input  logic              enable,
    input  logic              SETSTATE_SELECT,
    input  logic [SW-1:0]     ASSIGN_STATE,
    input  logic              tbl_we,
    input  logic [SW+XW-1:0]  tbl_addr,
    input  logic [SW:0]       tbl_wdata,
    output logic [SW:0]       tbl_rdata,
    output logic [SW-1:0]     Y,
    output logic              changed,
    output logic [CW-1:0]     trans_cnt
);

    localparam int AW    = SW + XW;
    localparam int DEPTH = 1 << AW;

    // Each entry is {valid, next_state}; held in flops so reset can clear the whole table in one edge.
    logic [SW:0]    tbl [DEPTH];
    logic [SW-1:0]  state;
    logic [SW-1:0]  state_nxt;
    logic           step_load;
    logic [AW-1:0]  step_idx;
    logic [SW:0]    step_ent;

    assign step_idx = {state, X};
    assign step_ent = tbl[step_idx];
    assign Y        = state;

    always_comb begin
        state_nxt = state;
        step_load = 1'b0;
        if (SETSTATE_SELECT) begin
            state_nxt = ASSIGN_STATE;
        end else if (enable && step_ent[SW]) begin
            state_nxt = step_ent[SW-1:0];
            step_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_STATE;
            trans_cnt <= '0;
            changed   <= 1'b0;
            tbl_rdata <= '0;
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
        end else begin
            state     <= state_nxt;
            changed   <= (state_nxt != state);
            // Reads take the pre-edge contents, so a same-edge write returns the old entry.
            tbl_rdata <= tbl[tbl_addr];
            if (step_load)
                trans_cnt <= trans_cnt + 1'b1;
            if (tbl_we)
                tbl[tbl_addr] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_core_logic_prog.sv
// Directed plus random bench for core_logic_prog, checked cycle-by-cycle against a table model.
module tb_core_logic_prog;

    localparam int SW = 4;
    localparam int XW = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [XW-1:0]     X = '0;
    logic              enable = 1'b0;
    logic              SETSTATE_SELECT = 1'b0;
    logic [SW-1:0]     ASSIGN_STATE = '0;
    logic              tbl_we = 1'b0;
    logic [SW+XW-1:0]  tbl_addr = '0;
    logic [SW:0]       tbl_wdata = '0;
    logic [SW:0]       tbl_rdata;
    logic [SW-1:0]     Y;
    logic              changed;
    logic [CW-1:0]     trans_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    core_logic_prog #(.SW(SW), .XW(XW), .CW(CW), .RESET_STATE(4'h0)) dut (
        .clk(clk), .rst(rst), .X(X), .enable(enable),
        .SETSTATE_SELECT(SETSTATE_SELECT), .ASSIGN_STATE(ASSIGN_STATE),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .tbl_rdata(tbl_rdata), .Y(Y), .changed(changed), .trans_cnt(trans_cnt)
    );

    always #5 clk = ~clk;

    // Model: the table is an array, a step is a lookup, the counter is plain modular arithmetic.
    logic [SW:0]    m_tbl [256];
    logic [SW-1:0]  m_state;
    logic [CW-1:0]  m_cnt;
    logic           m_changed;
    logic [SW:0]    m_rdata;

    always @(posedge clk) begin
        logic [SW:0]   ent;
        logic [SW-1:0] prev;
        if (rst) begin
            m_state = 4'h0; m_cnt = '0; m_changed = 1'b0; m_rdata = '0;
            for (int i = 0; i < 256; i++) m_tbl[i] = '0;
        end else begin
            ent = m_tbl[{m_state, X}];
            prev = m_state;
            m_rdata = m_tbl[tbl_addr];
            if (SETSTATE_SELECT) m_state = ASSIGN_STATE;
            else if (enable && ent[SW]) begin
                m_state = ent[SW-1:0];
                m_cnt = m_cnt + 1;
            end
            m_changed = (m_state != prev);
            if (tbl_we) m_tbl[tbl_addr] = tbl_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cyc_Y", 32'(Y), 32'(m_state));
            chk("cyc_changed", 32'(changed), 32'(m_changed));
            chk("cyc_trans_cnt", 32'(trans_cnt), 32'(m_cnt));
            chk("cyc_rdata", 32'(tbl_rdata), 32'(m_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [SW:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic force_state(input logic [SW-1:0] s);
        SETSTATE_SELECT = 1'b1; ASSIGN_STATE = s;
        tick();
        SETSTATE_SELECT = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_Y", 32'(Y), 0);
        chk("rst_cnt", 32'(trans_cnt), 0);
        chk("rst_changed", 32'(changed), 0);
        chk("rst_rdata", 32'(tbl_rdata), 0);

        // Empty table: random X never moves the state.
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            X = 4'($urandom);
            tick();
            chk("empty_Y", 32'(Y), 0);
            chk("empty_changed", 32'(changed), 0);
        end
        chk("empty_cnt", 32'(trans_cnt), 0);

        // Two programmed steps, with an enable=0 hold between them.
        enable = 1'b0;
        wr(8'h01, 5'h12);
        wr(8'h26, 5'h17);
        enable = 1'b1; X = 4'd1;
        tick();
        chk("step1_Y", 32'(Y), 2);
        chk("step1_changed", 32'(changed), 1);
        enable = 1'b0; X = 4'd6;
        tick();
        chk("hold_Y", 32'(Y), 2);
        chk("hold_changed", 32'(changed), 0);
        enable = 1'b1;
        tick();
        chk("step2_Y", 32'(Y), 7);
        chk("step2_changed", 32'(changed), 1);
        chk("step2_cnt", 32'(trans_cnt), 2);

        // Forced load ignores enable and does not count.
        enable = 1'b0;
        force_state(4'hD);
        chk("force_Y", 32'(Y), 4'hD);
        chk("force_changed", 32'(changed), 1);
        chk("force_cnt", 32'(trans_cnt), 2);

        // Step and write to the same entry on one edge: step and readback see the old entry.
        wr(8'h20, 5'h19);
        force_state(4'h2);
        tbl_we = 1'b1; tbl_addr = 8'h20; tbl_wdata = 5'h00;
        enable = 1'b1; X = 4'd0;
        tick();
        tbl_we = 1'b0; enable = 1'b0;
        chk("rbw_Y", 32'(Y), 9);
        chk("rbw_cnt", 32'(trans_cnt), 3);
        chk("rbw_rdata", 32'(tbl_rdata), 5'h19);
        force_state(4'h2);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("inval_Y", 32'(Y), 2);
        chk("inval_changed", 32'(changed), 0);
        chk("inval_cnt", 32'(trans_cnt), 3);
        chk("inval_rdata", 32'(tbl_rdata), 0);

        // Self-loop counts every step and wraps the 4-bit counter.
        rst = 1'b1; tick(); rst = 1'b0;
        wr(8'h33, 5'h13);
        force_state(4'h3);
        enable = 1'b1; X = 4'd3;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("loop_changed", 32'(changed), 0);
        end
        chk("loop_cnt", 32'(trans_cnt), 1);
        chk("loop_Y", 32'(Y), 3);

        // Reset beats a same-edge write and a valid step.
        rst = 1'b1; tbl_we = 1'b1; tbl_addr = 8'h33; tbl_wdata = 5'h15;
        tick();
        rst = 1'b0; tbl_we = 1'b0;
        chk("rstw_Y", 32'(Y), 0);
        chk("rstw_cnt", 32'(trans_cnt), 0);
        chk("rstw_rdata", 32'(tbl_rdata), 0);
        tick();
        chk("rstw_readback", 32'(tbl_rdata), 0);
        chk("rstw_hold", 32'(Y), 0);

        // Random mix; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            tbl_we = ($urandom_range(0, 2) == 0);
            tbl_addr = 8'($urandom);
            tbl_wdata = 5'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            SETSTATE_SELECT = ($urandom_range(0, 9) == 0);
            ASSIGN_STATE = 4'($urandom);
            X = 4'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
